// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//
// Front end for the user push-buttons. Each raw, asynchronous, active-low
// button pin passes through a two-flop synchroniser into clk. A per-key
// counter then requires a new level to persist for DEBOUNCE_CYCLES
// consecutive cycles before the clean level on key_out follows it. Any
// return to the current key_out level restarts the qualification from zero.
//
// Optional feature macro: KEY_DEBOUNCE_EDGE_EN
//   When defined, key_press / key_release are added. Each is a registered
//   one-cycle pulse that coincides with the first cycle key_out shows the
//   new level. When undefined, neither port nor its registers exist, and
//   key_out behaves the same as in the other build.
//
// Parameters
//   NUM_KEYS         number of independent button channels
//   DEBOUNCE_CYCLES  cycles a new level must persist (>= 1)
//   CNT_W            per-key counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk          in   1         system clock
//   reset        in   1         synchronous, active-high reset
//   raw_key      in   NUM_KEYS  raw button pins, active-low (0 = pressed)
//   key_out      out  NUM_KEYS  debounced level, active-low
//   key_press    out  NUM_KEYS  debounced press pulse (KEY_DEBOUNCE_EDGE_EN)
//   key_release  out  NUM_KEYS  debounced release pulse (KEY_DEBOUNCE_EDGE_EN)
// ---------------------------------------------------------------------------
module key_debouncer #(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] raw_key,
    output logic [NUM_KEYS-1:0] key_out
`ifdef KEY_DEBOUNCE_EDGE_EN
    ,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
`endif
);

    // Terminal count. The counter saturates here and never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                armed;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [CNT_W-1:0]    cnt      [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_next [NUM_KEYS];
    logic [NUM_KEYS-1:0] qualify;
    logic [NUM_KEYS-1:0] key_next;

    // The first edge after reset release only arms the front end. The
    // synchroniser starts sampling the pins one edge later. As a result, a
    // key held through reset qualifies at edge r+2+DEBOUNCE_CYCLES and not
    // one edge earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Two-flop synchroniser. The flops reset to all ones, which means
    // "released". Only sync2 is used by the logic below.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            if (armed) begin
                sync1 <= raw_key;
            end
            sync2 <= sync1;
        end
    end

    // Per-key qualification. A key whose level agrees with key_out has
    // nothing pending, so its counter is held at zero. While the level
    // differs, the counter advances. On the cycle the counter is already at
    // terminal count, the new level is accepted and the counter restarts.
    always_comb begin
        qualify  = '0;
        key_next = key_out;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != key_out[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    qualify[i]  = 1'b1;
                    key_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers for the debounced level and the per-key counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_out <= '1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_out <= key_next;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef KEY_DEBOUNCE_EDGE_EN
    // Edge pulses are registered on the same edge that updates key_out, so
    // each pulse lines up with the first cycle the new level is visible.
    // A qualifying key always differs from key_out. Therefore sync2 alone
    // tells which way the key moved.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_press   <= qualify & ~sync2;
            key_release <= qualify &  sync2;
        end
    end
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
//
// Self-checking bench for key_debouncer. It contains two instances:
//   dut       DEBOUNCE_CYCLES=4, CNT_W=3 (main behaviour)
//   dut_fast  DEBOUNCE_CYCLES=1, CNT_W=1 (minimum qualification period)
//
// Each vector holds one clock edge of stimulus and the outputs expected
// after that edge. Expected values are pushed to a scoreboard queue when
// stimulus is driven. They are popped and compared shortly after the edge.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int NK = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [NK-1:0] raw_key  = '1;
    logic [NK-1:0] raw_fast = '1;
    logic [NK-1:0] key_out;
    logic [NK-1:0] key_out_fast;
`ifdef KEY_DEBOUNCE_EDGE_EN
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_press_fast;
    logic [NK-1:0] key_release_fast;
`endif

    typedef struct {
        logic          rst;
        logic [NK-1:0] raw;
        logic [NK-1:0] raw_f;
        logic [NK-1:0] exp_out;
        logic [NK-1:0] exp_press;
        logic [NK-1:0] exp_rel;
        logic [NK-1:0] exp_out_f;
        logic [NK-1:0] exp_press_f;
        logic [NK-1:0] exp_rel_f;
    } vec_t;

    vec_t vectors[$];
    vec_t expq[$];
    int   compared   = 0;
    int   mismatched = 0;

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_key     (raw_key),
        .key_out     (key_out)
`ifdef KEY_DEBOUNCE_EDGE_EN
        ,
        .key_press   (key_press),
        .key_release (key_release)
`endif
    );

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (1)
    ) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .raw_key     (raw_fast),
        .key_out     (key_out_fast)
`ifdef KEY_DEBOUNCE_EDGE_EN
        ,
        .key_press   (key_press_fast),
        .key_release (key_release_fast)
`endif
    );

    always #5 clk = ~clk;

    // Builds one vector that leaves the fast instance idle and released.
    function automatic vec_t mk(input logic rst, input logic [NK-1:0] raw,
                                input logic [NK-1:0] out, input logic [NK-1:0] press,
                                input logic [NK-1:0] rel);
        vec_t v;
        v.rst         = rst;
        v.raw         = raw;
        v.exp_out     = out;
        v.exp_press   = press;
        v.exp_rel     = rel;
        v.raw_f       = '1;
        v.exp_out_f   = '1;
        v.exp_press_f = '0;
        v.exp_rel_f   = '0;
        return v;
    endfunction

    // Appends n copies of one vector to the table.
    function automatic void add(input logic rst, input logic [NK-1:0] raw,
                                input logic [NK-1:0] out, input logic [NK-1:0] press,
                                input logic [NK-1:0] rel, input int n);
        for (int j = 0; j < n; j++) begin
            vectors.push_back(mk(rst, raw, out, press, rel));
        end
    endfunction

    task automatic check(input string name, input int row,
                         input logic [NK-1:0] act, input logic [NK-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset    = v.rst;
        raw_key  = v.raw;
        raw_fast = v.raw_f;
        expq.push_back(v);
    endtask

    task automatic checkOutput(input int row);
        vec_t e;
        @(posedge clk);
        #1;
        compared++;
        if (expq.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_underflow row %0d: got 0 entries, expected 1", row);
        end else begin
            compared--;
            e = expq.pop_front();
            check("key_out", row, key_out, e.exp_out);
            check("key_out_fast", row, key_out_fast, e.exp_out_f);
`ifdef KEY_DEBOUNCE_EDGE_EN
            check("key_press", row, key_press, e.exp_press);
            check("key_release", row, key_release, e.exp_rel);
            check("key_press_fast", row, key_press_fast, e.exp_press_f);
            check("key_release_fast", row, key_release_fast, e.exp_rel_f);
`endif
        end
    endtask

    initial begin
        int   row;
        vec_t v;

        // Test 1: all keys held low through a 3-cycle reset. The first
        // edge with reset low is r, and key_out falls at r+6.
        add(1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 3);
        add(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 6);
        add(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1);
        add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        add(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 5);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2);

        // Test 2: key0 pressed at edge k. It appears at k+5 and is then
        // released.
        add(1'b0, 8'hFE, 8'hFF, 8'h00, 8'h00, 5);
        add(1'b0, 8'hFE, 8'hFE, 8'h01, 8'h00, 1);
        add(1'b0, 8'hFE, 8'hFE, 8'h00, 8'h00, 2);
        add(1'b0, 8'hFF, 8'hFE, 8'h00, 8'h00, 5);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h01, 1);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2);

        // Test 3: key0 bounces low 3 / high 1 / low 3. Each low run stops
        // one short of qualifying.
        add(1'b0, 8'hFE, 8'hFF, 8'h00, 8'h00, 3);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
        add(1'b0, 8'hFE, 8'hFF, 8'h00, 8'h00, 3);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 6);

        // Test 4: keys 7 and 0 change together and qualify on the same edge.
        add(1'b0, 8'h7E, 8'hFF, 8'h00, 8'h00, 5);
        add(1'b0, 8'h7E, 8'h7E, 8'h81, 8'h00, 1);
        add(1'b0, 8'h7E, 8'h7E, 8'h00, 8'h00, 2);
        add(1'b0, 8'hFF, 8'h7E, 8'h00, 8'h00, 5);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h81, 1);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2);

        // Test 5: reset arrives while cnt[3]=2. The pending press is lost,
        // and key3 re-qualifies at r+6.
        add(1'b0, 8'hF7, 8'hFF, 8'h00, 8'h00, 4);
        add(1'b1, 8'hF7, 8'hFF, 8'h00, 8'h00, 2);
        add(1'b0, 8'hF7, 8'hFF, 8'h00, 8'h00, 6);
        add(1'b0, 8'hF7, 8'hF7, 8'h08, 8'h00, 1);
        add(1'b0, 8'hF7, 8'hF7, 8'h00, 8'h00, 2);
        add(1'b0, 8'hFF, 8'hF7, 8'h00, 8'h00, 5);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h08, 1);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2);

        $display("[TB] applying %0d table vectors", vectors.size());
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i]);
            checkOutput(i);
        end
        row = vectors.size();

        // Test 6: key5 is low for one sampled cycle on both instances. The
        // 1-cycle instance passes it at k+2 for exactly one cycle. The
        // 4-cycle instance rejects it.
        v = mk(1'b0, 8'hDF, 8'hFF, 8'h00, 8'h00);
        v.raw_f = 8'hDF;
        applyStimulus(v);
        checkOutput(row++);
        v = mk(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
        applyStimulus(v);
        checkOutput(row++);
        v.exp_out_f   = 8'hDF;
        v.exp_press_f = 8'h20;
        applyStimulus(v);
        checkOutput(row++);
        v.exp_out_f   = 8'hFF;
        v.exp_press_f = 8'h00;
        v.exp_rel_f   = 8'h20;
        applyStimulus(v);
        checkOutput(row++);
        v.exp_rel_f = 8'h00;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v);
            checkOutput(row++);
        end

        compared++;
        if (expq.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
